// File: rtl/audio_pll_supervisor.sv
// Audio PLL supervisor: holds the PLL in reset, qualifies the synchronised locked flag and holds the audio domain in reset until the clock is stable.
// Define AUDIO_PLL_MAX_RETRY_EN to build the retry counter and the sticky FAIL state.
module audio_pll_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 17
`ifdef AUDIO_PLL_MAX_RETRY_EN
  , parameter int MAX_RETRIES = 4
`endif
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       domain_rst,
  output logic       ready,
  output logic [7:0] relock_count,
  output logic       fail
);

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_QUALIFY   = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

`ifdef AUDIO_PLL_MAX_RETRY_EN
  localparam int RETRY_W = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES - 1);
  logic [RETRY_W-1:0] retry_q;
`endif

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       relock_cnt_q;
  logic             sync1_q;
  logic             sync2_q;
  logic             lock_s;

  assign lock_s = sync2_q;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q      <= S_RESET;
      cnt_q        <= '0;
      relock_cnt_q <= '0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
`ifdef AUDIO_PLL_MAX_RETRY_EN
      retry_q      <= '0;
`endif
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_q + 1'b1;
      if (relock_req) begin
        // Restart wins over everything, including a loss of lock in RUN.
        state_q <= S_RESET;
        cnt_q   <= '0;
`ifdef AUDIO_PLL_MAX_RETRY_EN
        retry_q <= '0;
`endif
      end else begin
        unique case (state_q)
          S_RESET: begin
            if (cnt_q == RST_LAST) begin
              state_q <= S_WAIT_LOCK;
              cnt_q   <= '0;
            end
          end
          S_WAIT_LOCK: begin
            if (lock_s) begin
              state_q <= S_QUALIFY;
              cnt_q   <= '0;
            end else if (cnt_q == TIMEOUT_LAST) begin
              cnt_q <= '0;
`ifdef AUDIO_PLL_MAX_RETRY_EN
              if (retry_q == RETRY_LAST) begin
                state_q <= S_FAIL;
              end else begin
                state_q <= S_RESET;
                retry_q <= retry_q + 1'b1;
              end
`else
              state_q <= S_RESET;
`endif
            end
          end
          S_QUALIFY: begin
            if (!lock_s) begin
              state_q <= S_WAIT_LOCK;
              cnt_q   <= '0;
            end else if (cnt_q == STABLE_LAST) begin
              state_q <= S_RUN;
              cnt_q   <= '0;
`ifdef AUDIO_PLL_MAX_RETRY_EN
              retry_q <= '0;
`endif
            end
          end
          S_RUN: begin
            cnt_q <= '0;
            if (!lock_s) begin
              state_q <= S_RESET;
              if (relock_cnt_q != 8'hFF) relock_cnt_q <= relock_cnt_q + 8'd1;
            end
          end
          S_FAIL: begin
            cnt_q <= '0;
          end
          default: begin
            state_q <= S_RESET;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign pll_rst      = (state_q == S_RESET);
  assign domain_rst   = (state_q != S_RUN);
  assign ready        = (state_q == S_RUN);
  assign relock_count = relock_cnt_q;
`ifdef AUDIO_PLL_MAX_RETRY_EN
  assign fail = (state_q == S_FAIL);
`else
  assign fail = 1'b0;
`endif

endmodule

// File: tb/tb_audio_pll_supervisor.sv
// Directed bench for audio_pll_supervisor with RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2.
module tb_audio_pll_supervisor;
  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst;
  logic       domain_rst;
  logic       ready;
  logic [7:0] relock_count;
  logic       fail;

  int errors = 0;
  int checks = 0;

  audio_pll_supervisor #(
    .RST_CYCLES(4),
    .LOCK_TIMEOUT(32),
    .STABLE_CYCLES(8),
    .CNT_W(17)
`ifdef AUDIO_PLL_MAX_RETRY_EN
    , .MAX_RETRIES(2)
`endif
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .pll_locked(pll_locked),
    .relock_req(relock_req),
    .pll_rst(pll_rst),
    .domain_rst(domain_rst),
    .ready(ready),
    .relock_count(relock_count),
    .fail(fail)
  );

  always #10 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  // Leaves rst released 1 ns after an edge; the next edge is edge 1.
  task automatic apply_reset(input logic lock);
    rst = 1'b1;
    relock_req = 1'b0;
    pll_locked = lock;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL reset_pll_rst got %b want 1", pll_rst); end
    checks++; if (domain_rst !== 1'b1) begin errors++; $display("FAIL reset_domain_rst got %b want 1", domain_rst); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL reset_fail got %b want 0", fail); end
    checks++; if (relock_count !== 8'd0) begin errors++; $display("FAIL reset_relock_count got %0d want 0", relock_count); end
  endtask

  task automatic test_lock_sequence();
    apply_reset(1'b0);
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 13) pll_locked = 1'b1;
      if (k == 3) begin
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL seq_pll_rst_c3 got %b want 1", pll_rst); end
      end
      if (k == 4) begin
        checks++; if (pll_rst !== 1'b0) begin errors++; $display("FAIL seq_pll_rst_c4 got %b want 0", pll_rst); end
      end
      if (k == 23) begin
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL seq_ready_early got %b want 0", ready); end
      end
      if (k == 24) begin
        checks++; if (ready !== 1'b1 || domain_rst !== 1'b0)
          begin errors++; $display("FAIL seq_ready got ready=%b domain_rst=%b want 1/0", ready, domain_rst); end
      end
    end
  endtask

  task automatic test_loss_saturation();
    logic missed;
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL loss_ready_hold got %b want 1", ready); end
    tick();
    checks++; if (pll_rst !== 1'b1 || ready !== 1'b0 || relock_count !== 8'd1)
      begin errors++; $display("FAIL loss_first got pll_rst=%b ready=%b count=%0d want 1/0/1", pll_rst, ready, relock_count); end
    missed = 1'b0;
    for (int n = 2; n <= 256; n++) begin
      for (int w = 0; w < 64 && !ready; w++) tick();
      if (!ready) missed = 1'b1;
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      tick();
      tick();
      if (!pll_rst) missed = 1'b1;
      if (n == 255) begin
        checks++; if (relock_count !== 8'd255) begin errors++; $display("FAIL loss_count_255 got %0d want 255", relock_count); end
      end
    end
    checks++; if (missed) begin errors++; $display("FAIL loss_loop got missed=1 want 0"); end
    checks++; if (relock_count !== 8'd255) begin errors++; $display("FAIL loss_saturate got %0d want 255", relock_count); end
  endtask

  task automatic test_rst_mid_qualify();
    for (int k = 0; k < 7; k++) tick();
    checks++; if (pll_rst !== 1'b0 || ready !== 1'b0 || domain_rst !== 1'b1)
      begin errors++; $display("FAIL midq_state got pll_rst=%b ready=%b domain_rst=%b want 0/0/1", pll_rst, ready, domain_rst); end
    rst = 1'b1;
    #1;
    checks++; if (pll_rst !== 1'b1 || domain_rst !== 1'b1 || ready !== 1'b0 || fail !== 1'b0 || relock_count !== 8'd0)
      begin errors++; $display("FAIL midq_rst got pll_rst=%b domain_rst=%b ready=%b fail=%b count=%0d want 1/1/0/0/0",
                               pll_rst, domain_rst, ready, fail, relock_count); end
  endtask

  task automatic test_glitch_qualify();
    apply_reset(1'b1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 8) pll_locked = 1'b0;
      if (k == 9) pll_locked = 1'b1;
      if (k == 11) begin
        checks++; if (pll_rst !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL glitch_wait got pll_rst=%b ready=%b want 0/0", pll_rst, ready); end
      end
      if (k == 13 || k == 19) begin
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL glitch_ready_early_c%0d got %b want 0", k, ready); end
      end
      if (k == 20) begin
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL glitch_ready got %b want 1", ready); end
      end
    end
  endtask

  task automatic test_relock_in_reset();
    apply_reset(1'b0);
    tick();
    tick();
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    tick(); tick(); tick();
    checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL rstreq_hold got %b want 1", pll_rst); end
    tick();
    checks++; if (pll_rst !== 1'b0) begin errors++; $display("FAIL rstreq_release got %b want 0", pll_rst); end
  endtask

  task automatic test_relock_vs_loss();
    apply_reset(1'b1);
    for (int k = 1; k <= 14; k++) tick();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rvl_run got %b want 1", ready); end
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    checks++; if (pll_rst !== 1'b1 || ready !== 1'b0 || relock_count !== 8'd0)
      begin errors++; $display("FAIL rvl_reset got pll_rst=%b ready=%b count=%0d want 1/0/0", pll_rst, ready, relock_count); end
  endtask

  task automatic test_timeout_retry();
    apply_reset(1'b0);
    for (int k = 1; k <= 72; k++) begin
      tick();
      if (k == 35 || k == 40 || k == 71) begin
        checks++; if (pll_rst !== 1'b0) begin errors++; $display("FAIL to_pll_rst_c%0d got %b want 0", k, pll_rst); end
      end
      if (k == 36 || k == 39) begin
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL to_pll_rst_c%0d got %b want 1", k, pll_rst); end
      end
    end
`ifdef AUDIO_PLL_MAX_RETRY_EN
    checks++; if (fail !== 1'b1 || pll_rst !== 1'b0) begin errors++; $display("FAIL to_fail got fail=%b pll_rst=%b want 1/0", fail, pll_rst); end
    for (int k = 0; k < 40; k++) tick();
    checks++; if (fail !== 1'b1 || pll_rst !== 1'b0) begin errors++; $display("FAIL to_fail_sticky got fail=%b pll_rst=%b want 1/0", fail, pll_rst); end
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    checks++; if (fail !== 1'b0 || pll_rst !== 1'b1) begin errors++; $display("FAIL to_fail_clear got fail=%b pll_rst=%b want 0/1", fail, pll_rst); end
`else
    checks++; if (fail !== 1'b0 || pll_rst !== 1'b1) begin errors++; $display("FAIL to_second got fail=%b pll_rst=%b want 0/1", fail, pll_rst); end
    for (int k = 73; k <= 108; k++) tick();
    checks++; if (pll_rst !== 1'b1 || fail !== 1'b0) begin errors++; $display("FAIL to_third got pll_rst=%b fail=%b want 1/0", pll_rst, fail); end
`endif
  endtask

  initial begin
    test_reset();
    test_lock_sequence();
    test_loss_saturation();
    test_rst_mid_qualify();
    test_glitch_qualify();
    test_relock_in_reset();
    test_relock_vs_loss();
    test_timeout_retry();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
